data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with fixed access latency, byte-enabled writes
// and an error response for misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is accepted on the rising edge where the FSM is IDLE and
  // req_i=1; stall_o is high from that cycle until the ack_o cycle, when it drops.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 2);
  localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            err_q;
  logic            addr_bad;
  logic            finish;

  logic [31:0] mem [DEPTH_WORDS];

  assign addr_bad  = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= DEPTH_L);
  assign finish    = (state == WAIT) && (cnt == 4'd0);
  assign stall_o   = ((state == IDLE) && req_i) || (state == WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            be_q    <= be_i;
            err_q   <= addr_bad;
            cnt     <= CNT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Counter holds at zero on the completing edge, so it never wraps.
          if (cnt == 4'd0) begin
            state <= RESP;
            ack_o <= 1'b1;
            err_o <= err_q;
            if (err_q)      rdata_o <= 32'd0;
            else if (!we_q) rdata_o <= mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; an abort forces IDLE before the completing edge.
  always_ff @(posedge clk_i) begin
    if (finish && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=2 instance for the short-latency case.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];
  logic [1:0]  dstate[2];

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
    .stall_o(stall[0]), .err_o(err[0]), .dbg_state(dstate[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
    .stall_o(stall[1]), .err_o(err[1]), .dbg_state(dstate[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request on instance d starting in the current cycle (cycle 0).
  // Fields are scrambled after accept; req stays high until the ack cycle.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output int ack_cyc, output int ack_cnt, output logic [15:0] stall_bits,
                        output logic [31:0] rd, output logic er, output logic stray_err);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    ack_cyc = -1; ack_cnt = 0; stall_bits = '0; rd = 'x; er = 1'bx; stray_err = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      stall_bits[c] = stall[d];
      if (ack[d]) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = c;
        rd = rdata[d];
        er = err[d];
      end else if (err[d]) begin
        stray_err = 1'b1;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
      end
      if (ack_cyc >= 0) begin
        req[d] = 1'b0;
        break;
      end
    end
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ack[d], stall[d], err[d], rdata[d], dstate[d]} !== 36'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ack=%b stall=%b err=%b rdata=%h state=%0d, required all 0",
                 d, ack[d], stall[d], err[d], rdata[d], dstate[d]);
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_timing();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || an !== 1) begin
      errors++; $display("FAIL write_ack_cycle: ack at %0d (count %0d), required 4 (count 1)", ac, an);
    end
    checks++;
    if (sb !== 16'h000F) begin
      errors++; $display("FAIL write_stall: stall bits %h, required 000f", sb);
    end
    checks++;
    if (er !== 1'b0 || se !== 1'b0) begin
      errors++; $display("FAIL write_err: err=%b stray=%b, required 0/0", er, se);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL write_rdata_hold: rdata %h, required 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL b2b_read: ack at %0d rdata %h err %b, required 4 deadbeef 0", ac, rd, er);
    end
  endtask

  task automatic test_partial_write();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL partial_write: ack at %0d rdata %h, required 4 deadbeef", ac, rd);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      errors++; $display("FAIL partial_read: rdata %h err %b, required de22be44 0", rd, er);
    end
    do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || er !== 1'b0) begin
      errors++; $display("FAIL be_zero_write: ack at %0d err %b, required 4 0", ac, er);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (rd !== 32'hDE22BE44) begin
      errors++; $display("FAIL be_zero_read: rdata %h, required de22be44", rd);
    end
  endtask

  task automatic test_errors();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    do_req(0, 1'b0, 32'h12, 32'h0, 4'hF, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || er !== 1'b1 || rd !== 32'h0 || se !== 1'b0) begin
      errors++; $display("FAIL err_misaligned: ack %0d err %b rdata %h stray %b, required 4 1 0 0", ac, er, rd, se);
    end
    do_req(0, 1'b0, 32'h400, 32'h0, 4'hF, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_range: ack %0d err %b rdata %h, required 4 1 0", ac, er, rd);
    end
    do_req(0, 1'b1, 32'h13, 32'h0, 4'hF, ac, an, sb, rd, er, se);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_write: err %b rdata %h, required 1 0", er, rd);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      errors++; $display("FAIL err_storage: rdata %h err %b, required de22be44 0", rd, er);
    end
  endtask

  task automatic test_reset_abort();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    int ack_seen;
    do_req(0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, ac, an, sb, rd, er, se);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL abort_setup: rdata %h, required a5a5a5a5", rd);
    end
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55; be[0] = 4'hF;
    ack_seen = 0;
    repeat (2) begin
      @(negedge clk); if (ack[0]) ack_seen++;
      @(posedge clk); #1;
    end
    rst = 1'b0; req[0] = 1'b0;
    #1;
    checks++;
    if ({ack[0], stall[0], err[0], rdata[0], dstate[0]} !== 36'd0) begin
      errors++;
      $display("FAIL abort_immediate: ack=%b stall=%b err=%b rdata=%h state=%0d, required all 0",
               ack[0], stall[0], err[0], rdata[0], dstate[0]);
    end
    repeat (2) begin
      @(negedge clk); if (ack[0]) ack_seen++;
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk); if (ack[0]) ack_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (ack_seen !== 0) begin
      errors++; $display("FAIL abort_no_ack: %0d ack cycles, required 0", ack_seen);
    end
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 4 || rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL abort_storage: ack %0d rdata %h err %b, required 4 a5a5a5a5 0", ac, rd, er);
    end
  endtask

  task automatic test_latency2();
    int ac, an; logic [15:0] sb; logic [31:0] rd; logic er, se;
    do_req(1, 1'b1, 32'h10, 32'h12345678, 4'hF, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 2 || an !== 1 || sb !== 16'h0003 || er !== 1'b0) begin
      errors++; $display("FAIL lat2_write: ack %0d cnt %0d stall %h err %b, required 2 1 0003 0", ac, an, sb, er);
    end
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, ac, an, sb, rd, er, se);
    checks++;
    if (ac !== 2 || rd !== 32'h12345678) begin
      errors++; $display("FAIL lat2_read: ack %0d rdata %h, required 2 12345678", ac, rd);
    end
  endtask

  task automatic test_idle();
    req[0] = 1'b0; req[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (stall[d] !== 1'b0 || ack[d] !== 1'b0 || err[d] !== 1'b0) begin
          errors++; $display("FAIL idle dut%0d cycle %0d: stall=%b ack=%b err=%b, required 0", d, c, stall[d], ack[d], err[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_back_to_back();
    test_partial_write();
    test_errors();
    test_reset_abort();
    test_latency2();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
